// File: rtl/aileron_valve_ctrl.sv
// aileron_valve_ctrl: rate-limited, side-interlocked thermometer valve driver for one aileron.
// Define AILERON_DEADTIME_EN to insert an all-off dead time of DEAD_CYCLES between side changes.
module aileron_valve_ctrl #(
   parameter int ANG_W       = 4,
   parameter int LEVELS      = 2,
   parameter int STEP_CYCLES = 4,
   parameter int DEAD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ang_valid,
   input  logic [ANG_W-1:0]  ang,
   output logic [LEVELS-1:0] valve_e,
   output logic [LEVELS-1:0] valve_d,
   output logic              busy
);
   localparam int MAG_W = ANG_W - 1;
   localparam int LVL_W = $clog2(LEVELS + 1);
   localparam int PRD_W = MAG_W + LVL_W;
   localparam int STP_W = $clog2(STEP_CYCLES + 1);

   localparam logic [LVL_W-1:0]  LVL_ZERO  = {LVL_W{1'b0}};
   localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
   localparam logic [STP_W-1:0]  STEP_ZERO = {STP_W{1'b0}};
   localparam logic [STP_W-1:0]  STEP_ONE  = STP_W'(1);
   localparam logic [STP_W-1:0]  STEP_LAST = STP_W'(STEP_CYCLES - 1);
   localparam logic [LEVELS-1:0] VALVES_OFF = {LEVELS{1'b0}};

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_RAMP = 2'd1;
`ifdef AILERON_DEADTIME_EN
   localparam logic [1:0] ST_DEAD = 2'd2;
   localparam int DED_W = $clog2(DEAD_CYCLES + 1);
   localparam logic [DED_W-1:0] DEAD_ZERO = {DED_W{1'b0}};
   localparam logic [DED_W-1:0] DEAD_ONE  = DED_W'(1);
   localparam logic [DED_W-1:0] DEAD_LAST = DED_W'(DEAD_CYCLES - 1);
`endif

   // Level 0 for zero magnitude, else 1 + floor(m*LEVELS / 2^MAG_W); never exceeds LEVELS.
   function automatic logic [LVL_W-1:0] mag_to_level(input logic [MAG_W-1:0] mag);
      logic [PRD_W-1:0] prod;
      logic [PRD_W-1:0] lvl;
      prod = PRD_W'(mag) * PRD_W'(LEVELS);
      lvl  = (prod >> MAG_W) + PRD_W'(1);
      return (mag == {MAG_W{1'b0}}) ? LVL_ZERO : LVL_W'(lvl);
   endfunction

   function automatic logic [LEVELS-1:0] thermo(input logic [LVL_W-1:0] lvl);
      logic [LEVELS-1:0] v;
      v = VALVES_OFF;
      for (int i = 0; i < LEVELS; i++) begin
         v[i] = (LVL_W'(i) < lvl);
      end
      return v;
   endfunction

   logic              r_tgt_side;
   logic [LVL_W-1:0]  r_tgt_lvl;
   logic              r_cur_side;
   logic [LVL_W-1:0]  r_cur_lvl;
   logic [1:0]        r_state;
   logic [STP_W-1:0]  r_step_cnt;
   logic [LEVELS-1:0] r_valve_e;
   logic [LEVELS-1:0] r_valve_d;
   logic              r_busy;

   logic [LVL_W-1:0]  w_cmd_lvl;
   logic              w_match;
   logic              w_eff_side;
   logic              w_eff_switch;
   logic              w_go_down;
   logic              w_step_done;
   logic [LVL_W-1:0]  w_step_lvl;
   logic [1:0]        w_nxt_state;
   logic              w_nxt_side;
   logic [LVL_W-1:0]  w_nxt_lvl;
   logic [STP_W-1:0]  w_nxt_step;
`ifdef AILERON_DEADTIME_EN
   logic [DED_W-1:0]  r_dead_cnt;
   logic [DED_W-1:0]  w_nxt_dead;
`else
   logic              w_unused_dead;
   // DEAD_CYCLES has no effect in this build.
   assign w_unused_dead = (DEAD_CYCLES > 0);
`endif

   assign w_cmd_lvl = mag_to_level(ang[MAG_W-1:0]);

   // A zero target carries no side, so it matches the current level 0 on either side.
   assign w_match = (r_tgt_lvl == r_cur_lvl) &&
                    ((r_tgt_lvl == LVL_ZERO) || (r_tgt_side == r_cur_side));

`ifdef AILERON_DEADTIME_EN
   assign w_eff_side = r_cur_side;
`else
   assign w_eff_side = ((r_cur_lvl == LVL_ZERO) && (r_tgt_lvl != LVL_ZERO)) ? r_tgt_side : r_cur_side;
`endif

   assign w_eff_switch = (r_tgt_lvl != LVL_ZERO) && (r_tgt_side != w_eff_side);
   assign w_go_down    = w_eff_switch || (r_tgt_lvl < r_cur_lvl);
   assign w_step_lvl   = w_go_down ? (r_cur_lvl - LVL_ONE) : (r_cur_lvl + LVL_ONE);
   assign w_step_done  = (r_step_cnt == STEP_LAST);

   // Command capture: the last strobed command wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tgt_side <= 1'b0;
         r_tgt_lvl  <= LVL_ZERO;
      end else if (ang_valid) begin
         r_tgt_side <= ang[ANG_W-1] & (w_cmd_lvl != LVL_ZERO);
         r_tgt_lvl  <= w_cmd_lvl;
      end
   end

   // Slew controller: next state, side, level and timers.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_side  = r_cur_side;
      w_nxt_lvl   = r_cur_lvl;
      w_nxt_step  = r_step_cnt;
`ifdef AILERON_DEADTIME_EN
      w_nxt_dead  = r_dead_cnt;
`endif
      case (r_state)
         ST_HOLD, ST_RAMP: begin
            if (w_match) begin
               w_nxt_state = ST_HOLD;
               w_nxt_step  = STEP_ZERO;
`ifdef AILERON_DEADTIME_EN
            end else if (w_eff_switch && (r_cur_lvl == LVL_ZERO)) begin
               // From HOLD the accepting edge already counts as the first dead cycle.
               w_nxt_step = STEP_ZERO;
               if ((r_state == ST_HOLD) && (DEAD_LAST == DEAD_ZERO)) begin
                  w_nxt_state = ST_RAMP;
                  w_nxt_side  = r_tgt_side;
               end else if (r_state == ST_HOLD) begin
                  w_nxt_state = ST_DEAD;
                  w_nxt_dead  = DEAD_ONE;
               end else begin
                  w_nxt_state = ST_DEAD;
                  w_nxt_dead  = DEAD_ZERO;
               end
`endif
            end else if (w_step_done) begin
               w_nxt_step = STEP_ZERO;
               w_nxt_lvl  = w_step_lvl;
               w_nxt_side = w_eff_side;
               if ((w_step_lvl == r_tgt_lvl) &&
                   ((r_tgt_lvl == LVL_ZERO) || (r_tgt_side == w_eff_side))) begin
                  w_nxt_state = ST_HOLD;
               end else if ((w_step_lvl == LVL_ZERO) && w_eff_switch) begin
`ifdef AILERON_DEADTIME_EN
                  w_nxt_state = ST_DEAD;
                  w_nxt_dead  = DEAD_ZERO;
`else
                  w_nxt_state = ST_RAMP;
                  w_nxt_side  = r_tgt_side;
`endif
               end else begin
                  w_nxt_state = ST_RAMP;
               end
            end else begin
               w_nxt_state = ST_RAMP;
               w_nxt_side  = w_eff_side;
               w_nxt_step  = r_step_cnt + STEP_ONE;
            end
         end
`ifdef AILERON_DEADTIME_EN
         ST_DEAD: begin
            if (w_match) begin
               w_nxt_state = ST_HOLD;
               w_nxt_step  = STEP_ZERO;
               w_nxt_dead  = DEAD_ZERO;
            end else if (r_dead_cnt == DEAD_LAST) begin
               w_nxt_state = ST_RAMP;
               w_nxt_side  = r_tgt_side;
               w_nxt_step  = STEP_ZERO;
               w_nxt_dead  = DEAD_ZERO;
            end else begin
               w_nxt_dead  = r_dead_cnt + DEAD_ONE;
            end
         end
`endif
         default: begin
            w_nxt_state = ST_HOLD;
            w_nxt_lvl   = LVL_ZERO;
            w_nxt_step  = STEP_ZERO;
         end
      endcase
   end

   // State and output registers; outputs decode the next level so they change on the step edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_HOLD;
         r_cur_side <= 1'b0;
         r_cur_lvl  <= LVL_ZERO;
         r_step_cnt <= STEP_ZERO;
`ifdef AILERON_DEADTIME_EN
         r_dead_cnt <= DEAD_ZERO;
`endif
         r_valve_e  <= VALVES_OFF;
         r_valve_d  <= VALVES_OFF;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_nxt_state;
         r_cur_side <= w_nxt_side;
         r_cur_lvl  <= w_nxt_lvl;
         r_step_cnt <= w_nxt_step;
`ifdef AILERON_DEADTIME_EN
         r_dead_cnt <= w_nxt_dead;
`endif
         r_valve_e  <= w_nxt_side ? thermo(w_nxt_lvl) : VALVES_OFF;
         r_valve_d  <= w_nxt_side ? VALVES_OFF : thermo(w_nxt_lvl);
         r_busy     <= (w_nxt_state != ST_HOLD);
      end
   end

   assign valve_e = r_valve_e;
   assign valve_d = r_valve_d;
   assign busy    = r_busy;

endmodule

// File: tb/tb_aileron_valve_ctrl.sv
// Directed bench for aileron_valve_ctrl: default instance plus a 5-bit / 3-level / 1-cycle-step instance.
module tb_aileron_valve_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       ang_valid;
   logic [3:0] ang;
   logic [1:0] valve_e;
   logic [1:0] valve_d;
   logic       busy;
   logic       ang_valid2;
   logic [4:0] ang2;
   logic [2:0] valve_e2;
   logic [2:0] valve_d2;
   logic       busy2;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef AILERON_DEADTIME_EN
   localparam int SW_EDGE   = 14;
   localparam int ZERO_EDGE = 6;
`else
   localparam int SW_EDGE   = 12;
   localparam int ZERO_EDGE = 4;
`endif

   aileron_valve_ctrl dut (
      .clk(clk), .rst(rst), .ang_valid(ang_valid), .ang(ang),
      .valve_e(valve_e), .valve_d(valve_d), .busy(busy)
   );

   aileron_valve_ctrl #(.ANG_W(5), .LEVELS(3), .STEP_CYCLES(1), .DEAD_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .ang_valid(ang_valid2), .ang(ang2),
      .valve_e(valve_e2), .valve_d(valve_d2), .busy(busy2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [3:0] a);
      ang       = a;
      ang_valid = 1'b1;
      tick();
      ang_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ang_valid = 1'b0; ang = 4'b0000; ang_valid2 = 1'b0; ang2 = 5'b00000;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_checks++; if (valve_e !== 2'b00) begin n_fail++; $display("FAIL reset_valve_e: got %b expected 00", valve_e); end
      n_checks++; if (valve_d !== 2'b00) begin n_fail++; $display("FAIL reset_valve_d: got %b expected 00", valve_d); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if ({valve_e2, valve_d2, busy2} !== 7'b0000000) begin n_fail++; $display("FAIL reset_dut2: got %b expected 0000000", {valve_e2, valve_d2, busy2}); end
   endtask

   task automatic test_ramp_same_side();
      logic [1:0] exp_d;
      accept(4'b0101);
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_d = (e < 4) ? 2'b00 : ((e < 8) ? 2'b01 : 2'b11);
         n_checks++; if (valve_d !== exp_d) begin n_fail++; $display("FAIL ramp_valve_d edge %0d: got %b expected %b", e, valve_d, exp_d); end
         n_checks++; if (valve_e !== 2'b00) begin n_fail++; $display("FAIL ramp_valve_e edge %0d: got %b expected 00", e, valve_e); end
         n_checks++; if (busy !== (e <= 7)) begin n_fail++; $display("FAIL ramp_busy edge %0d: got %b expected %b", e, busy, (e <= 7)); end
      end
   endtask

   task automatic test_side_switch();
      logic [1:0] exp_d;
      logic [1:0] exp_e;
      accept(4'b1001);
      for (int e = 1; e <= 16; e++) begin
         tick();
         exp_d = (e < 4) ? 2'b11 : ((e < 8) ? 2'b01 : 2'b00);
         exp_e = (e < SW_EDGE) ? 2'b00 : 2'b01;
         n_checks++; if (valve_d !== exp_d) begin n_fail++; $display("FAIL switch_valve_d edge %0d: got %b expected %b", e, valve_d, exp_d); end
         n_checks++; if (valve_e !== exp_e) begin n_fail++; $display("FAIL switch_valve_e edge %0d: got %b expected %b", e, valve_e, exp_e); end
         n_checks++; if (busy !== (e < SW_EDGE)) begin n_fail++; $display("FAIL switch_busy edge %0d: got %b expected %b", e, busy, (e < SW_EDGE)); end
      end
   endtask

   task automatic test_return_to_zero();
      logic [1:0] exp_e;
      logic [3:0] cmds [3];
      cmds[0] = 4'b1000; cmds[1] = 4'b1001; cmds[2] = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         accept(cmds[c]);
         for (int e = 1; e <= 6; e++) begin
            tick();
            exp_e = ((e < 4) != (c == 1)) ? 2'b01 : 2'b00;
            n_checks++; if (valve_e !== exp_e) begin n_fail++; $display("FAIL zero_valve_e cmd %0d edge %0d: got %b expected %b", c, e, valve_e, exp_e); end
            n_checks++; if (valve_d !== 2'b00) begin n_fail++; $display("FAIL zero_valve_d cmd %0d edge %0d: got %b expected 00", c, e, valve_d); end
            n_checks++; if (busy !== (e < 4)) begin n_fail++; $display("FAIL zero_busy cmd %0d edge %0d: got %b expected %b", c, e, busy, (e < 4)); end
         end
      end
   endtask

   task automatic test_retarget();
      logic [1:0] exp_d;
      pulse_reset();
      accept(4'b0111);
      for (int e = 1; e <= 12; e++) begin
         ang_valid = (e == 2);
         ang       = 4'b0001;
         tick();
         ang_valid = 1'b0;
         exp_d = (e < 4) ? 2'b00 : 2'b01;
         n_checks++; if (valve_d !== exp_d) begin n_fail++; $display("FAIL retarget_valve_d edge %0d: got %b expected %b", e, valve_d, exp_d); end
         n_checks++; if (busy !== (e < 4)) begin n_fail++; $display("FAIL retarget_busy edge %0d: got %b expected %b", e, busy, (e < 4)); end
      end
   endtask

   task automatic test_reset_mid_ramp();
      logic [1:0] exp_d;
      pulse_reset();
      accept(4'b0111);
      for (int e = 1; e <= 12; e++) begin
         rst = (e == 6);
         tick();
         rst = 1'b0;
         exp_d = (e >= 4 && e < 6) ? 2'b01 : 2'b00;
         n_checks++; if (valve_d !== exp_d) begin n_fail++; $display("FAIL rstmid_valve_d edge %0d: got %b expected %b", e, valve_d, exp_d); end
         n_checks++; if (valve_e !== 2'b00) begin n_fail++; $display("FAIL rstmid_valve_e edge %0d: got %b expected 00", e, valve_e); end
         n_checks++; if (busy !== (e < 6)) begin n_fail++; $display("FAIL rstmid_busy edge %0d: got %b expected %b", e, busy, (e < 6)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_d;
      pulse_reset();
      ang       = 4'b0101;
      ang_valid = 1'b1;
      tick();
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_d = (e < 4) ? 2'b00 : ((e < 8) ? 2'b01 : 2'b11);
         n_checks++; if (valve_d !== exp_d) begin n_fail++; $display("FAIL held_valve_d edge %0d: got %b expected %b", e, valve_d, exp_d); end
         n_checks++; if (busy !== (e <= 7)) begin n_fail++; $display("FAIL held_busy edge %0d: got %b expected %b", e, busy, (e <= 7)); end
      end
      ang_valid = 1'b0;
   endtask

   task automatic test_switch_from_zero();
      logic [1:0] exp_e;
      pulse_reset();
      accept(4'b1001);
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp_e = (e < ZERO_EDGE) ? 2'b00 : 2'b01;
         n_checks++; if (valve_e !== exp_e) begin n_fail++; $display("FAIL zswitch_valve_e edge %0d: got %b expected %b", e, valve_e, exp_e); end
         n_checks++; if (valve_d !== 2'b00) begin n_fail++; $display("FAIL zswitch_valve_d edge %0d: got %b expected 00", e, valve_d); end
         n_checks++; if (busy !== (e < ZERO_EDGE)) begin n_fail++; $display("FAIL zswitch_busy edge %0d: got %b expected %b", e, busy, (e < ZERO_EDGE)); end
      end
   endtask

   task automatic test_wide_params();
      logic [3:0] mags [3];
      logic [2:0] exps [3];
      mags[0] = 4'd5;  exps[0] = 3'b001;
      mags[1] = 4'd6;  exps[1] = 3'b011;
      mags[2] = 4'd15; exps[2] = 3'b111;
      for (int k = 0; k < 3; k++) begin
         ang2       = {1'b0, mags[k]};
         ang_valid2 = 1'b1;
         tick();
         ang_valid2 = 1'b0;
         tick();
         n_checks++; if (valve_d2 !== exps[k]) begin n_fail++; $display("FAIL wide_valve_d m=%0d: got %b expected %b", mags[k], valve_d2, exps[k]); end
         n_checks++; if (valve_e2 !== 3'b000) begin n_fail++; $display("FAIL wide_valve_e m=%0d: got %b expected 000", mags[k], valve_e2); end
         n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL wide_busy m=%0d: got %b expected 0", mags[k], busy2); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_same_side();
      test_side_switch();
      test_return_to_zero();
      test_retarget();
      test_reset_mid_ramp();
      test_back_to_back();
      test_switch_from_zero();
      test_wide_params();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
